// File: rtl/custom_instr_pkg.sv
// Shared types for the custom-instruction / X-interface memory channel.
package custom_instr_pkg;

   localparam int unsigned XIF_ID_WIDTH   = 4;
   localparam int unsigned XIF_ADDR_WIDTH = 32;
   localparam int unsigned XIF_DATA_WIDTH = 32;
   localparam int unsigned XIF_BE_WIDTH   = 4;

   // Access size as carried on the memory channel; encoding 3 is illegal.
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } mem_size_e;

   // Captured coprocessor memory request.
   typedef struct packed {
      logic [XIF_ID_WIDTH-1:0]   id;
      logic [XIF_ADDR_WIDTH-1:0] addr;
      logic                      we;
      logic [1:0]                size;
      logic [XIF_DATA_WIDTH-1:0] wdata;
   } xif_mem_req_t;

endpackage

// File: rtl/xif_mem_resp_lane.sv
// Byte-lane steering: byte enables, store replication, load extraction and
// the misaligned/illegal-size flag, all from the low address bits and size.
module xif_mem_lane
   import custom_instr_pkg::*;
(
   input  logic [1:0]                addr_lo,
   input  logic [1:0]                size,
   input  logic [XIF_DATA_WIDTH-1:0] wdata,
   input  logic [XIF_DATA_WIDTH-1:0] rdata,
   output logic [XIF_BE_WIDTH-1:0]   be_c,
   output logic [XIF_DATA_WIDTH-1:0] wdata_c,
   output logic [XIF_DATA_WIDTH-1:0] rdata_c,
   output logic                      err_c
);

   logic [XIF_DATA_WIDTH-1:0] rdata_sh;

   // Move the addressed byte down to lane 0 before masking to size.
   assign rdata_sh = rdata >> {addr_lo, 3'b000};

   // Lane decode per access size; illegal size yields no lanes.
   always_comb begin
      be_c    = '0;
      wdata_c = '0;
      rdata_c = '0;
      err_c   = 1'b0;
      case (size)
         SIZE_BYTE: begin
            be_c    = 4'b0001 << addr_lo;
            wdata_c = {4{wdata[7:0]}};
            rdata_c = {24'h0, rdata_sh[7:0]};
         end
         SIZE_HALF: begin
            be_c    = 4'b0011 << addr_lo;
            wdata_c = {2{wdata[15:0]}};
            rdata_c = {16'h0, rdata_sh[15:0]};
            err_c   = addr_lo[0];
         end
         SIZE_WORD: begin
            be_c    = 4'b1111;
            wdata_c = wdata;
            rdata_c = rdata_sh;
            err_c   = (addr_lo != 2'b00);
         end
         default: err_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/xif_mem_resp.sv
// Core-side responder for the X-interface memory channel: one request at a
// time, executed on the OBI data bus, answered with a single result pulse.
module xif_mem_resp
   import custom_instr_pkg::*;
#(
   parameter int unsigned ID_WIDTH = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                mem_valid_i,
   output logic                mem_ready_o,
   input  logic [ID_WIDTH-1:0] mem_id_i,
   input  logic [31:0]         mem_addr_i,
   input  logic                mem_we_i,
   input  logic [1:0]          mem_size_i,
   input  logic [31:0]         mem_wdata_i,
   output logic                mem_result_valid_o,
   output logic [ID_WIDTH-1:0] mem_result_id_o,
   output logic [31:0]         mem_result_rdata_o,
   output logic                mem_result_err_o,
   output logic                data_req_o,
   input  logic                data_gnt_i,
   output logic [31:0]         data_addr_o,
   output logic                data_we_o,
   output logic [3:0]          data_be_o,
   output logic [31:0]         data_wdata_o,
   input  logic                data_rvalid_i,
   input  logic [31:0]         data_rdata_i,
   input  logic                data_err_i,
   output logic                busy_o
);

   typedef enum logic [1:0] {
      IDLE,
      BUS_REQ,
      BUS_WAIT,
      RESULT
   } state_e;

   state_e       state_q, state_d;
   xif_mem_req_t req_q;
   logic [3:0]   be_q;
   logic [31:0]  res_rdata_q;
   logic         res_err_q;

   logic         in_idle;
   logic         accept;
   logic         capture;
   logic [1:0]   lane_addr;
   logic [1:0]   lane_size;
   logic [3:0]   lane_be;
   logic [31:0]  lane_wdata;
   logic [31:0]  lane_rdata;
   logic         lane_err;

   assign in_idle = (state_q == IDLE);
   assign accept  = in_idle && mem_valid_i;
   assign capture = (state_q == BUS_WAIT) && data_rvalid_i;

   // Lane logic sees the incoming request while idle and the held request
   // afterwards; its results only ever land in registers.
   assign lane_addr = in_idle ? mem_addr_i[1:0] : req_q.addr[1:0];
   assign lane_size = in_idle ? mem_size_i      : req_q.size;

   xif_mem_lane u_lane (
      .addr_lo (lane_addr),
      .size    (lane_size),
      .wdata   (mem_wdata_i),
      .rdata   (data_rdata_i),
      .be_c    (lane_be),
      .wdata_c (lane_wdata),
      .rdata_c (lane_rdata),
      .err_c   (lane_err)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; bad requests skip the bus entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (mem_valid_i) state_d = lane_err ? RESULT : BUS_REQ;
         BUS_REQ:  if (data_gnt_i) state_d = BUS_WAIT;
         BUS_WAIT: if (data_rvalid_i) state_d = RESULT;
         RESULT:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Request capture on accept, response capture on rvalid.
   // req_q.wdata holds the already lane-replicated store data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q       <= '0;
         be_q        <= '0;
         res_rdata_q <= '0;
         res_err_q   <= 1'b0;
      end else if (accept) begin
         req_q.id    <= XIF_ID_WIDTH'(mem_id_i);
         req_q.addr  <= mem_addr_i;
         req_q.we    <= mem_we_i;
         req_q.size  <= mem_size_i;
         req_q.wdata <= lane_wdata;
         be_q        <= lane_err ? 4'b0000 : lane_be;
         res_rdata_q <= '0;
         res_err_q   <= lane_err;
      end else if (capture) begin
         res_err_q   <= data_err_i;
         res_rdata_q <= (data_err_i || req_q.we) ? 32'h0 : lane_rdata;
      end
   end

   assign mem_ready_o        = in_idle;
   assign busy_o             = !in_idle;
   assign mem_result_valid_o = (state_q == RESULT);
   assign mem_result_id_o    = ID_WIDTH'(req_q.id);
   assign mem_result_rdata_o = mem_result_valid_o ? res_rdata_q : 32'h0;
   assign mem_result_err_o   = mem_result_valid_o && res_err_q;

   assign data_req_o   = (state_q == BUS_REQ);
   assign data_addr_o  = {req_q.addr[31:2], 2'b00};
   assign data_we_o    = req_q.we;
   assign data_be_o    = be_q;
   assign data_wdata_o = req_q.wdata;

endmodule

// File: tb/tb_xif_mem_resp.sv
// Self-checking bench for xif_mem_resp: directed scenarios plus random traffic
// checked against an arithmetic reference model of the memory channel.
module tb_xif_mem_resp;

   localparam int unsigned ID_W = 4;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            mem_valid_i;
   logic            mem_ready_o;
   logic [ID_W-1:0] mem_id_i;
   logic [31:0]     mem_addr_i;
   logic            mem_we_i;
   logic [1:0]      mem_size_i;
   logic [31:0]     mem_wdata_i;
   logic            mem_result_valid_o;
   logic [ID_W-1:0] mem_result_id_o;
   logic [31:0]     mem_result_rdata_o;
   logic            mem_result_err_o;
   logic            data_req_o;
   logic            data_gnt_i;
   logic [31:0]     data_addr_o;
   logic            data_we_o;
   logic [3:0]      data_be_o;
   logic [31:0]     data_wdata_o;
   logic            data_rvalid_i;
   logic [31:0]     data_rdata_i;
   logic            data_err_i;
   logic            busy_o;

   int checks = 0;
   int errors = 0;

   xif_mem_resp #(.ID_WIDTH(ID_W)) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .mem_valid_i        (mem_valid_i),
      .mem_ready_o        (mem_ready_o),
      .mem_id_i           (mem_id_i),
      .mem_addr_i         (mem_addr_i),
      .mem_we_i           (mem_we_i),
      .mem_size_i         (mem_size_i),
      .mem_wdata_i        (mem_wdata_i),
      .mem_result_valid_o (mem_result_valid_o),
      .mem_result_id_o    (mem_result_id_o),
      .mem_result_rdata_o (mem_result_rdata_o),
      .mem_result_err_o   (mem_result_err_o),
      .data_req_o         (data_req_o),
      .data_gnt_i         (data_gnt_i),
      .data_addr_o        (data_addr_o),
      .data_we_o          (data_we_o),
      .data_be_o          (data_be_o),
      .data_wdata_o       (data_wdata_o),
      .data_rvalid_i      (data_rvalid_i),
      .data_rdata_i       (data_rdata_i),
      .data_err_i         (data_err_i),
      .busy_o             (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] size);
      return 1 << int'(size);
   endfunction

   function automatic bit is_bad(input logic [31:0] addr, input logic [1:0] size);
      int off;
      off = int'(addr % 32'd4);
      return (size == 2'd3) || ((off % nbytes(size)) != 0);
   endfunction

   function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic [1:0] size);
      int off;
      int n;
      logic [3:0] b;
      off = int'(addr % 32'd4);
      n   = nbytes(size);
      b   = 4'b0000;
      for (int i = 0; i < 4; i++) if (i >= off && i < off + n) b[i] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] wdata, input logic [1:0] size);
      int n;
      logic [31:0] w;
      n = nbytes(size);
      w = 32'h0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wdata[8*(i % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] addr, input logic [1:0] size,
                                             input logic [31:0] bus);
      int off;
      logic [63:0] mask;
      logic [31:0] sh;
      off  = int'(addr % 32'd4);
      mask = (64'd1 << (8 * nbytes(size))) - 64'd1;
      sh   = bus >> (8 * off);
      return sh & mask[31:0];
   endfunction

   // One complete request: drive it, play the OBI slave, check every cycle.
   task automatic txn(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [1:0] size,
                      input logic we, input logic [31:0] wdata, input logic [31:0] bus_rdata,
                      input logic bus_err, input int gnt_wait, input int rv_wait);
      bit          mis;
      logic        err_e;
      logic [31:0] rd_e;
      mis   = is_bad(addr, size);
      err_e = mis || bus_err;
      rd_e  = (err_e || we) ? 32'h0 : exp_rdata(addr, size, bus_rdata);

      chk1("ready_before_accept", mem_ready_o, 1'b1);
      mem_valid_i = 1'b1;
      mem_id_i    = id;
      mem_addr_i  = addr;
      mem_we_i    = we;
      mem_size_i  = size;
      mem_wdata_i = wdata;
      @(negedge clk_i);
      mem_valid_i = 1'b0;
      mem_addr_i  = $urandom;
      mem_wdata_i = $urandom;
      mem_size_i  = 2'($urandom_range(0, 3));

      if (!mis) begin
         for (int c = 0; c <= gnt_wait; c++) begin
            chk1("req_high", data_req_o, 1'b1);
            chk32("req_addr", data_addr_o, addr & 32'hFFFF_FFFC);
            chk32("req_be", 32'(data_be_o), 32'(exp_be(addr, size)));
            chk32("req_wdata", data_wdata_o, exp_wdata(wdata, size));
            chk1("req_we", data_we_o, we);
            chk1("ready_low_busreq", mem_ready_o, 1'b0);
            chk1("busy_busreq", busy_o, 1'b1);
            chk1("no_result_busreq", mem_result_valid_o, 1'b0);
            data_gnt_i    = (c == gnt_wait);
            data_rvalid_i = (c != gnt_wait) && ($urandom_range(0, 1) == 1);
            data_err_i    = data_rvalid_i;
            data_rdata_i  = $urandom;
            @(negedge clk_i);
         end
         data_gnt_i = 1'b0;
         for (int c = 0; c <= rv_wait; c++) begin
            chk1("req_dropped", data_req_o, 1'b0);
            chk1("no_result_wait", mem_result_valid_o, 1'b0);
            chk1("busy_wait", busy_o, 1'b1);
            data_gnt_i    = ($urandom_range(0, 1) == 1);
            data_rvalid_i = (c == rv_wait);
            data_rdata_i  = (c == rv_wait) ? bus_rdata : $urandom;
            data_err_i    = (c == rv_wait) ? bus_err : 1'b0;
            @(negedge clk_i);
         end
         data_gnt_i    = 1'b0;
         data_rvalid_i = 1'b0;
         data_err_i    = 1'b0;
      end else begin
         chk1("bad_no_req", data_req_o, 1'b0);
      end

      chk1("result_valid", mem_result_valid_o, 1'b1);
      chk32("result_id", 32'(mem_result_id_o), 32'(id));
      chk32("result_rdata", mem_result_rdata_o, rd_e);
      chk1("result_err", mem_result_err_o, err_e);
      chk1("ready_low_result", mem_ready_o, 1'b0);
      chk1("req_low_result", data_req_o, 1'b0);
      @(negedge clk_i);
      chk1("result_one_cycle", mem_result_valid_o, 1'b0);
      chk1("ready_after", mem_ready_o, 1'b1);
      chk1("idle_not_busy", busy_o, 1'b0);
   endtask

   initial begin
      rst_ni        = 1'b0;
      mem_valid_i   = 1'b0;
      mem_id_i      = '0;
      mem_addr_i    = 32'h0;
      mem_we_i      = 1'b0;
      mem_size_i    = 2'd0;
      mem_wdata_i   = 32'h0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_rdata_i  = 32'h0;
      data_err_i    = 1'b0;
      repeat (2) @(negedge clk_i);

      // Reset values.
      chk1("rst_ready", mem_ready_o, 1'b1);
      chk1("rst_busy", busy_o, 1'b0);
      chk1("rst_req", data_req_o, 1'b0);
      chk1("rst_result_valid", mem_result_valid_o, 1'b0);
      chk32("rst_result_id", 32'(mem_result_id_o), 32'h0);
      chk32("rst_result_rdata", mem_result_rdata_o, 32'h0);
      chk1("rst_result_err", mem_result_err_o, 1'b0);
      chk32("rst_addr", data_addr_o, 32'h0);
      chk32("rst_be", 32'(data_be_o), 32'h0);
      chk32("rst_wdata", data_wdata_o, 32'h0);
      chk1("rst_we", data_we_o, 1'b0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Word load, immediate grant, rvalid one cycle later.
      txn(4'd3, 32'h100, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0);
      // Byte store to the top lane.
      txn(4'd5, 32'h103, 2'd0, 1'b1, 32'h0000_00A5, 32'h1234_5678, 1'b0, 0, 0);
      // Half load from upper half with three grant-wait cycles.
      txn(4'd7, 32'h102, 2'd1, 1'b0, 32'h0, 32'h8001_7FFF, 1'b0, 3, 1);
      // Misaligned word, then illegal size.
      txn(4'd9, 32'h101, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
      txn(4'd10, 32'h100, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
      // Misaligned half.
      txn(4'd11, 32'h203, 2'd1, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 0, 0);
      // Bus error on load.
      txn(4'd12, 32'h200, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b1, 1, 2);

      // Spurious bus response and grant while idle.
      data_rvalid_i = 1'b1;
      data_gnt_i    = 1'b1;
      data_err_i    = 1'b1;
      data_rdata_i  = 32'h5555_AAAA;
      @(negedge clk_i);
      data_rvalid_i = 1'b0;
      data_gnt_i    = 1'b0;
      data_err_i    = 1'b0;
      chk1("spurious_no_result", mem_result_valid_o, 1'b0);
      chk1("spurious_no_req", data_req_o, 1'b0);
      chk1("spurious_ready", mem_ready_o, 1'b1);

      // Reset while waiting for the bus response.
      mem_valid_i = 1'b1;
      mem_id_i    = 4'd14;
      mem_addr_i  = 32'h300;
      mem_size_i  = 2'd2;
      mem_we_i    = 1'b0;
      @(negedge clk_i);
      mem_valid_i = 1'b0;
      data_gnt_i  = 1'b1;
      @(negedge clk_i);
      data_gnt_i = 1'b0;
      chk1("pre_reset_busy", busy_o, 1'b1);
      rst_ni = 1'b0;
      #1;
      chk1("midrst_ready", mem_ready_o, 1'b1);
      chk1("midrst_busy", busy_o, 1'b0);
      chk1("midrst_req", data_req_o, 1'b0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h0BAD_0BAD;
      @(negedge clk_i);
      data_rvalid_i = 1'b0;
      chk1("late_rvalid_no_result", mem_result_valid_o, 1'b0);
      chk1("late_rvalid_ready", mem_ready_o, 1'b1);
      chk1("late_rvalid_busy", busy_o, 1'b0);
      @(negedge clk_i);
      chk1("late_rvalid_no_result2", mem_result_valid_o, 1'b0);

      // Random traffic against the reference model.
      for (int t = 0; t < 60; t++) begin
         logic [31:0] a;
         logic [1:0]  s;
         s = 2'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 3) != 0 && s != 2'd3) a = a & ~(32'(nbytes(s)) - 32'd1);
         txn(4'($urandom), a, s, 1'($urandom), $urandom, $urandom,
             ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
